// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_pkg
// Description : Shared definitions for the NTT stage sequencer: FSM state
//               encoding, default parameter values and counter typedef.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

  localparam int NTT_DEF_NUM_STAGES      = 3;
  localparam int NTT_DEF_BU_PER_STAGE    = 64;
  localparam int NTT_DEF_INIT_CYCLES     = 256;
  localparam int NTT_DEF_DRAIN_CYCLES    = 12;
  localparam int NTT_DEF_MAX_OUTSTANDING = 16;
  localparam int NTT_DEF_CNT_W           = 16;

  typedef logic [NTT_DEF_CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } ntt_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/ntt_outstanding_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ntt_outstanding_tracker
// Description : Up/down counter of in-flight butterflies with full and zero
//               flags. A decrement while empty is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_outstanding_tracker
  import ntt_pkg::*;
#(
  parameter int MAX_OUTSTANDING = NTT_DEF_MAX_OUTSTANDING,
  parameter int CNT_W           = NTT_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             zero_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: simultaneous inc/dec cancel, underflowing decrement ignored
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (!inc_i && dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == MAX_C);
  assign zero_o  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ntt_stage_sequencer
// Description : Runs NUM_STAGES NTT stages of BU_PER_STAGE butterflies each,
//               with a twiddle init phase, an outstanding-butterfly limit and
//               a drain window between stages.
//               Optional: NTT_SEQ_PERF_EN adds cycle_cnt, stall_cnt and err.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_stage_sequencer
  import ntt_pkg::*;
#(
  parameter int NUM_STAGES      = NTT_DEF_NUM_STAGES,
  parameter int BU_PER_STAGE    = NTT_DEF_BU_PER_STAGE,
  parameter int INIT_CYCLES     = NTT_DEF_INIT_CYCLES,
  parameter int DRAIN_CYCLES    = NTT_DEF_DRAIN_CYCLES,
  parameter int MAX_OUTSTANDING = NTT_DEF_MAX_OUTSTANDING,
  parameter int CNT_W           = NTT_DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        agu_valid,
  input  logic                        r_valid_out,
  input  logic                        ntt_done,
  output logic                        tf_init,
  output logic                        tf_ren,
  output logic [$clog2(NUM_STAGES):0] stage_idx,
  output logic                        agu_enable,
  output logic                        r_enable,
  output logic                        w_enable,
  output logic                        ntt_enable,
  output logic                        busy,
  output logic                        done
`ifdef NTT_SEQ_PERF_EN
  ,
  output logic [31:0]                 cycle_cnt,
  output logic [31:0]                 stall_cnt,
  output logic                        err
`endif
);

  localparam int SW = $clog2(NUM_STAGES) + 1;
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BU_C       = CNT_W'(BU_PER_STAGE);
  localparam logic [CNT_W-1:0] BU_LAST    = CNT_W'(BU_PER_STAGE - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [SW-1:0]    LAST_STAGE = SW'(NUM_STAGES - 1);

  // Every count must be representable in a CNT_W-bit counter
  generate
    if ((NUM_STAGES < 1) || (BU_PER_STAGE < 1) || (INIT_CYCLES < 1) ||
        (DRAIN_CYCLES < 1) || (MAX_OUTSTANDING < 1) || (CNT_W < 2) || (CNT_W > 62) ||
        (64'(BU_PER_STAGE) >= (64'(1) << CNT_W)) ||
        (64'(INIT_CYCLES) >= (64'(1) << CNT_W)) ||
        (64'(DRAIN_CYCLES) >= (64'(1) << CNT_W)) ||
        (64'(MAX_OUTSTANDING) >= (64'(1) << CNT_W))) begin : g_param_check
      $error("ntt_stage_sequencer: parameter out of range for CNT_W");
    end
  endgenerate

  ntt_seq_state_e   state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [SW-1:0]    stage_q, stage_d;

  logic             w_issue_pend;
  logic             w_ren;
  logic             w_wen;
  logic             w_full;
  logic             w_zero;
  logic [CNT_W-1:0] w_outst;
  logic             w_drained;
  logic             w_drain_exit;

  ntt_outstanding_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_outst (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (w_ren),
    .dec_i   (w_wen),
    .count_o (w_outst),
    .full_o  (w_full),
    .zero_o  (w_zero)
  );

  // Issue/write-back qualifiers; drain completes once this cycle's write empties the pipe
  always_comb begin
    w_issue_pend = (state_q == ST_RUN) && (issue_cnt_q < BU_C);
    w_ren        = w_issue_pend && agu_valid && !w_full;
    w_wen        = ((state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_FIN)) && ntt_done;
    w_drained    = w_zero || ((w_outst == CNT_W'(1)) && w_wen);
    w_drain_exit = (state_q == ST_DRAIN) && (drain_cnt_q == DRAIN_LAST) && w_drained;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_INIT;
      ST_INIT:  if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
      ST_RUN:   if (w_ren && (issue_cnt_q == BU_LAST)) state_d = ST_DRAIN;
      ST_DRAIN: if (w_drain_exit) state_d = (stage_q == LAST_STAGE) ? ST_FIN : ST_RUN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: enables are combinational from state, counters and inputs
  always_comb begin
    tf_init    = (state_q == ST_INIT);
    agu_enable = w_issue_pend;
    r_enable   = w_ren;
    tf_ren     = w_ren;
    w_enable   = w_wen;
    ntt_enable = ((state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_FIN)) && r_valid_out;
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_FIN);
  end

  // Counter next values; stage_idx is kept after FIN and only cleared by start
  always_comb begin
    init_cnt_d  = init_cnt_q;
    issue_cnt_d = issue_cnt_q;
    drain_cnt_d = drain_cnt_q;
    stage_d     = stage_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          init_cnt_d = '0;
          stage_d    = '0;
        end
      end
      ST_INIT: begin
        init_cnt_d = init_cnt_q + CNT_W'(1);
        if (init_cnt_q == INIT_LAST) begin
          issue_cnt_d = '0;
          stage_d     = '0;
        end
      end
      ST_RUN: begin
        if (w_ren) issue_cnt_d = issue_cnt_q + CNT_W'(1);
        if (w_ren && (issue_cnt_q == BU_LAST)) drain_cnt_d = '0;
      end
      ST_DRAIN: begin
        if (drain_cnt_q != DRAIN_LAST) drain_cnt_d = drain_cnt_q + CNT_W'(1);
        if (w_drain_exit && (stage_q != LAST_STAGE)) begin
          stage_d     = stage_q + SW'(1);
          issue_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_q  <= '0;
      issue_cnt_q <= '0;
      drain_cnt_q <= '0;
      stage_q     <= '0;
    end else begin
      init_cnt_q  <= init_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      stage_q     <= stage_d;
    end
  end

  assign stage_idx = stage_q;

`ifdef NTT_SEQ_PERF_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        err_q;

  // Performance counters: clear on start, count while busy, freeze in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (start) begin
          cycle_cnt_q <= '0;
          stall_cnt_q <= '0;
        end
      end else begin
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
        if (w_issue_pend && !w_ren) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (w_wen && !w_ren && w_zero) err_q <= 1'b1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_stage_sequencer
// Description : Directed self-checking bench for ntt_stage_sequencer with
//               NUM_STAGES=3, BU_PER_STAGE=4, INIT_CYCLES=3, DRAIN_CYCLES=2,
//               MAX_OUTSTANDING=2. Optional: NTT_SEQ_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_stage_sequencer;

  localparam int NS = 3;
  localparam int BU = 4;
  localparam int IC = 3;
  localparam int DC = 2;
  localparam int MO = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       agu_valid = 1'b0;
  logic       r_valid_out = 1'b0;
  logic       ntt_done = 1'b0;
  logic       tf_init, tf_ren, agu_enable, r_enable, w_enable, ntt_enable, busy, done;
  logic [2:0] stage_idx;
`ifdef NTT_SEQ_PERF_EN
  logic [31:0] cycle_cnt, stall_cnt;
  logic        err;
`endif

  ntt_stage_sequencer #(
    .NUM_STAGES      (NS),
    .BU_PER_STAGE    (BU),
    .INIT_CYCLES     (IC),
    .DRAIN_CYCLES    (DC),
    .MAX_OUTSTANDING (MO),
    .CNT_W           (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .agu_valid   (agu_valid),
    .r_valid_out (r_valid_out),
    .ntt_done    (ntt_done),
    .tf_init     (tf_init),
    .tf_ren      (tf_ren),
    .stage_idx   (stage_idx),
    .agu_enable  (agu_enable),
    .r_enable    (r_enable),
    .w_enable    (w_enable),
    .ntt_enable  (ntt_enable),
    .busy        (busy),
    .done        (done)
`ifdef NTT_SEQ_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .stall_cnt   (stall_cnt),
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Responder pipe and per-cycle observations
  logic [2:0] dp = '0;
  bit         man_mode = 1'b0;
  logic       o_ren, o_wen, o_done, o_tf, o_busy, o_agu;
  logic [2:0] o_stage;

  // Per-transform statistics
  int          n_ren, n_wen, n_done, n_tf, n_bad, last_s0, first_s1;
  int          ren_st[3];
  logic [31:0] ren_map;
  int          done_k;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observe one cycle mid-period, then drive next-cycle responder inputs
  task automatic tick();
    @(negedge clk);
    o_ren   = r_enable;
    o_wen   = w_enable;
    o_done  = done;
    o_tf    = tf_init;
    o_busy  = busy;
    o_agu   = agu_enable;
    o_stage = stage_idx;
    @(posedge clk);
    #1;
    dp          = {dp[1:0], r_valid_out};
    r_valid_out = o_ren;
    if (!man_mode) ntt_done = dp[2];
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    man_mode    = 1'b0;
    start       = 1'b0;
    agu_valid   = 1'b0;
    ntt_done    = 1'b0;
    r_valid_out = 1'b0;
    dp          = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic agu_pat(input int mode, input int k);
    case (mode)
      1:       return (k % 2 == 0);
      2:       return !((k == 4) || (k == 5));
      default: return 1'b1;
    endcase
  endfunction

  // One full transform from a start pulse at cycle 0, auto responder
  task automatic run_xform(input int mode);
    n_ren = 0; n_wen = 0; n_done = 0; n_tf = 0; n_bad = 0;
    last_s0 = -1; first_s1 = -1; ren_map = '0; done_k = -1;
    for (int s = 0; s < 3; s++) ren_st[s] = 0;
    for (int k = 0; (k < 200) && (done_k < 0); k++) begin
      start     = (k == 0);
      agu_valid = agu_pat(mode, k);
      tick();
      if (o_ren) begin
        n_ren++;
        if (o_stage < 3) ren_st[o_stage]++;
        if (!agu_valid) n_bad++;
        if (k < 32) ren_map[k] = 1'b1;
        if (o_stage == 0) last_s0 = k;
        if ((o_stage == 1) && (first_s1 < 0)) first_s1 = k;
      end
      if (o_wen) n_wen++;
      if (o_tf) n_tf++;
      if (o_done) begin
        n_done++;
        done_k = k;
      end
    end
    start     = 1'b0;
    agu_valid = 1'b1;
    repeat (3) begin
      tick();
      if (o_ren) n_ren++;
      if (o_wen) n_wen++;
      if (o_done) n_done++;
    end
    check_eq("done_seen", 32'(done_k >= 0), 1);
  endtask

  logic exp_ren, exp_w, exp_agu;

  initial begin
    // Reset state
    do_reset();
    tick();
    check_eq("rst_outputs", {busy, tf_init, r_enable, tf_ren, w_enable, ntt_enable,
                             agu_enable, done, stage_idx}, 0);

    // Full transform, constant agu_valid
    run_xform(0);
    check_eq("s1_ren_total", n_ren, 12);
    check_eq("s1_wen_total", n_wen, 12);
    check_eq("s1_done_pulses", n_done, 1);
    check_eq("s1_done_cycle", done_k, 37);
    check_eq("s1_tf_init_cycles", n_tf, IC);
    check_eq("s1_ren_map", {16'h0, ren_map[15:0]}, 32'h8630);
    check_eq("s1_ren_stage0", ren_st[0], 4);
    check_eq("s1_ren_stage1", ren_st[1], 4);
    check_eq("s1_ren_stage2", ren_st[2], 4);
    check_eq("s1_last_issue_s0", last_s0, 10);
    check_eq("s1_first_issue_s1", first_s1, 15);
    check_eq("s1_stage_hold", o_stage, 2);
    check_eq("s1_idle_busy", o_busy, 0);

    // Outstanding limit and drain hold with hand-scheduled write-backs
    do_reset();
    man_mode = 1'b1;
    for (int k = 0; k < 16; k++) begin
      start     = (k == 0);
      agu_valid = 1'b1;
      ntt_done  = (k == 7) || (k == 9) || (k == 11) || (k == 14);
      tick();
      exp_ren = (k == 4) || (k == 5) || (k == 8) || (k == 10) || (k == 15);
      exp_w   = (k >= 4) && ntt_done;
      exp_agu = ((k >= 4) && (k <= 10)) || (k == 15);
      check_eq($sformatf("dr_ren_k%0d", k), o_ren, exp_ren);
      check_eq($sformatf("dr_wen_k%0d", k), o_wen, exp_w);
      check_eq($sformatf("dr_agu_k%0d", k), o_agu, exp_agu);
      if (k >= 4) check_eq($sformatf("dr_stage_k%0d", k), o_stage, (k == 15) ? 1 : 0);
      if (k >= 1) check_eq($sformatf("dr_busy_k%0d", k), o_busy, 1);
    end

    // Toggled agu_valid
    do_reset();
    run_xform(1);
    check_eq("tg_ren_map", {16'h0, ren_map[15:0]}, 32'h1450);
    check_eq("tg_ren_total", n_ren, 12);
    check_eq("tg_ren_agu_low", n_bad, 0);
    check_eq("tg_done_pulses", n_done, 1);
    check_eq("tg_ren_stage0", ren_st[0], 4);

    // Reset during stage 1
    do_reset();
    agu_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      start = (k == 0);
      tick();
      if (o_stage == 1) break;
    end
    start = 1'b0;
    check_eq("mr_reached_s1", o_stage, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_outputs_zero", {busy, tf_init, r_enable, tf_ren, w_enable, ntt_enable,
                                 agu_enable, done, stage_idx}, 0);
    r_valid_out = 1'b0;
    ntt_done    = 1'b0;
    dp          = '0;
    n_done      = 0;
    repeat (2) begin
      tick();
      if (o_done) n_done++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      if (o_done) n_done++;
    end
    check_eq("mr_no_done", n_done, 0);
    run_xform(0);
    check_eq("mr_rerun_done_cycle", done_k, 37);
    check_eq("mr_rerun_ren_total", n_ren, 12);
    check_eq("mr_rerun_ren_s0", ren_st[0], 4);
    check_eq("mr_rerun_first_s1", first_s1, 15);

    // Two-cycle agu_valid gap at the start of stage 0
    do_reset();
    run_xform(2);
    check_eq("gp_ren_map", {16'h0, ren_map[15:0]}, 32'h18C0);
    check_eq("gp_done_cycle", done_k, 39);
    check_eq("gp_ren_total", n_ren, 12);
`ifdef NTT_SEQ_PERF_EN
    check_eq("gp_cycle_cnt", cycle_cnt, 32'(done_k));
    check_eq("gp_stall_cnt", stall_cnt, 11);
    check_eq("gp_err", err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
